// File: rtl/onehot_logger_pkg.sv
// onehot_logger_pkg: shared widths, entry layout and the vector encoder for onehot_event_logger
package onehot_logger_pkg;
    localparam int CODE_W = 3;
    localparam int STAMP_W = 8;
    localparam int VEC_W = 8;
    typedef struct packed {
        logic [CODE_W-1:0]  code;
        logic               err;
        logic [STAMP_W-1:0] stamp;
    } entry_t;
    function automatic logic [CODE_W:0] encode(input logic [VEC_W-1:0] v);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = VEC_W - 1; i >= 0; i--)
            if (v[i]) code = CODE_W'(i);
        return {code, $countones(v) != 1};
    endfunction
endpackage

// File: rtl/onehot_event_logger_if.sv
// onehot_event_logger_if: FWFT head-entry stream from the logger to its consumer
interface onehot_event_logger_if;
    import onehot_logger_pkg::*;
    logic                 out_valid;
    logic                 out_ready;
    logic [CODE_W-1:0]    out_code;
    logic                 out_err;
    logic [STAMP_W-1:0]   out_stamp;
    modport master (output out_valid, out_code, out_err, out_stamp, input out_ready);
    modport slave (input out_valid, out_code, out_err, out_stamp, output out_ready);
endinterface

// File: rtl/logger_fifo.sv
// logger_fifo: first-word-fall-through FIFO with occupancy output; head reads as zero while empty
module logger_fifo #(
    parameter int W = 4,
    parameter int DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          dout,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] level_q, level_d;
    logic do_push, do_pop;
    always_comb begin
        do_pop = pop && level_q != '0;
        do_push = push && (level_q != FULL || do_pop);
        wr_d = wr_q + AW'(do_push);
        rd_d = rd_q + AW'(do_pop);
        level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            level_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            level_q <= level_d;
        end
    end
    always_ff @(posedge clock)
        if (do_push) mem_q[wr_q] <= din;
    assign dout = level_q != '0 ? mem_q[rd_q] : '0;
    assign level = level_q;
endmodule

// File: rtl/onehot_event_logger.sv
// onehot_event_logger: logs changes of a one-hot vector into a FIFO; define ONEHOT_LOGGER_TIMESTAMP_EN for timestamps
module onehot_event_logger
    import onehot_logger_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [VEC_W-1:0]       in_data,
    onehot_event_logger_if.master  out_if,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clr_ovf,
    output logic [7:0]             drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [VEC_W-1:0] prev_q, prev_d;
    logic overflow_q, overflow_d;
    logic [7:0] drop_q, drop_d;
    logic event_hit, full, pop, drop;
    entry_t head;
`ifdef ONEHOT_LOGGER_TIMESTAMP_EN
    localparam int W = $bits(entry_t);
    logic [STAMP_W-1:0] cnt_q, cnt_d;
    logic [W-1:0] din, dout;
    always_comb cnt_d = cnt_q + 1'b1;
    always_ff @(posedge clock or posedge reset)
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign din = {encode(in_data), cnt_q};
    assign head = dout;
`else
    localparam int W = CODE_W + 1;
    logic [W-1:0] din, dout;
    assign din = encode(in_data);
    assign head = {dout, STAMP_W'(0)};
`endif
    always_comb begin
        prev_d = in_data;
        event_hit = in_data != prev_q;
        pop = out_if.out_valid && out_if.out_ready;
        full = level == (AW+1)'(DEPTH);
        drop = event_hit && full && !pop;
        overflow_d = clr_ovf ? 1'b0 : overflow_q | drop;
        drop_d = clr_ovf ? '0 : drop_q + 8'(drop && drop_q != 8'hff);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            overflow_q <= 1'b0;
            drop_q <= '0;
        end else begin
            prev_q <= prev_d;
            overflow_q <= overflow_d;
            drop_q <= drop_d;
        end
    end
    logger_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (event_hit),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .level (level)
    );
    assign out_if.out_valid = level != '0;
    assign out_if.out_code = head.code;
    assign out_if.out_err = head.err;
    assign out_if.out_stamp = head.stamp;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;
endmodule

// File: tb/tb_onehot_event_logger.sv
// tb_onehot_event_logger: table vectors, corner sequences and random stimulus against a queue-based reference model
module tb_onehot_event_logger;
    localparam int DEPTH = 4;
    logic clock, reset, clr_ovf, overflow;
    logic [7:0] in_data, drop_cnt;
    logic [2:0] level;
    onehot_event_logger_if bus();
    onehot_event_logger #(.DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .out_if   (bus),
        .level    (level),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .drop_cnt (drop_cnt)
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] code;
        logic       err;
        logic [7:0] stamp;
    } m_ent_t;
    typedef struct {
        logic [7:0] d;
        logic       r, c, v;
        logic [2:0] code;
        logic       err;
        logic [2:0] lvl;
        logic       ovf;
        logic [7:0] drop;
    } vec_t;

    m_ent_t m_q[$];
    logic [7:0] m_prev, m_cnt, m_drop;
    logic m_ovf;
    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic m_ent_t mk(input logic [7:0] d, input logic [7:0] cnt);
        m_ent_t e;
        int ones = 0;
        e.code = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (d[i]) begin
                e.code = 3'(i);
                ones++;
            end
        e.err = ones != 1;
`ifdef ONEHOT_LOGGER_TIMESTAMP_EN
        e.stamp = cnt;
`else
        e.stamp = 8'd0 & cnt;
`endif
        return e;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_prev = 8'd0;
        m_cnt = 8'd0;
        m_drop = 8'd0;
        m_ovf = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic v;
        v = m_q.size() != 0;
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, "_code"}, 32'(bus.out_code), v ? 32'(m_q[0].code) : 32'd0);
        chk({tag, "_err"}, 32'(bus.out_err), v ? 32'(m_q[0].err) : 32'd0);
        chk({tag, "_stamp"}, 32'(bus.out_stamp), v ? 32'(m_q[0].stamp) : 32'd0);
        chk({tag, "_level"}, 32'(level), 32'(m_q.size()));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_drop"}, 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic cycle(input logic [7:0] d, input logic r, input logic c, input string tag);
        logic ev, pop;
        m_ent_t e;
        in_data = d;
        bus.out_ready = r;
        clr_ovf = c;
        pop = r && m_q.size() != 0;
        ev = d != m_prev;
        e = mk(d, m_cnt);
        @(posedge clock);
        if (pop) m_q.delete(0);
        if (ev) begin
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else begin
                m_ovf = 1'b1;
                if (m_drop != 8'd255) m_drop++;
            end
        end
        if (c) begin
            m_ovf = 1'b0;
            m_drop = 8'd0;
        end
        m_prev = d;
        m_cnt++;
        @(negedge clock);
        check_model(tag);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        in_data = 8'd0;
        bus.out_ready = 1'b0;
        clr_ovf = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    vec_t tbl[22];

    initial begin
        tbl[0]  = '{8'h04, 0, 0, 1, 3'd2, 0, 3'd1, 0, 8'd0};
        tbl[1]  = '{8'h04, 1, 0, 0, 3'd0, 0, 3'd0, 0, 8'd0};
        tbl[2]  = '{8'h01, 0, 0, 1, 3'd0, 0, 3'd1, 0, 8'd0};
        tbl[3]  = '{8'h01, 0, 0, 1, 3'd0, 0, 3'd1, 0, 8'd0};
        tbl[4]  = '{8'h80, 0, 0, 1, 3'd0, 0, 3'd2, 0, 8'd0};
        tbl[5]  = '{8'h80, 1, 0, 1, 3'd7, 0, 3'd1, 0, 8'd0};
        tbl[6]  = '{8'h0A, 0, 0, 1, 3'd7, 0, 3'd2, 0, 8'd0};
        tbl[7]  = '{8'h00, 1, 0, 1, 3'd1, 1, 3'd2, 0, 8'd0};
        tbl[8]  = '{8'h00, 1, 0, 1, 3'd0, 1, 3'd1, 0, 8'd0};
        tbl[9]  = '{8'h00, 1, 0, 0, 3'd0, 0, 3'd0, 0, 8'd0};
        tbl[10] = '{8'h01, 0, 0, 1, 3'd0, 0, 3'd1, 0, 8'd0};
        tbl[11] = '{8'h02, 0, 0, 1, 3'd0, 0, 3'd2, 0, 8'd0};
        tbl[12] = '{8'h04, 0, 0, 1, 3'd0, 0, 3'd3, 0, 8'd0};
        tbl[13] = '{8'h08, 0, 0, 1, 3'd0, 0, 3'd4, 0, 8'd0};
        tbl[14] = '{8'h10, 0, 0, 1, 3'd0, 0, 3'd4, 1, 8'd1};
        tbl[15] = '{8'h20, 0, 0, 1, 3'd0, 0, 3'd4, 1, 8'd2};
        tbl[16] = '{8'h20, 0, 1, 1, 3'd0, 0, 3'd4, 0, 8'd0};
        tbl[17] = '{8'h40, 1, 0, 1, 3'd1, 0, 3'd4, 0, 8'd0};
        tbl[18] = '{8'h40, 1, 0, 1, 3'd2, 0, 3'd3, 0, 8'd0};
        tbl[19] = '{8'h40, 1, 0, 1, 3'd3, 0, 3'd2, 0, 8'd0};
        tbl[20] = '{8'h40, 1, 0, 1, 3'd6, 0, 3'd1, 0, 8'd0};
        tbl[21] = '{8'h40, 1, 0, 0, 3'd0, 0, 3'd0, 0, 8'd0};

        reset = 1'b1;
        in_data = 8'd0;
        bus.out_ready = 1'b0;
        clr_ovf = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_code", 32'(bus.out_code), 32'd0);
        do_reset();

        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].d, tbl[i].r, tbl[i].c, $sformatf("tbl%0d_model", i));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_code", i), 32'(bus.out_code), 32'(tbl[i].code));
            chk($sformatf("tbl%0d_err", i), 32'(bus.out_err), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].drop));
        end

        do_reset();
        cycle(8'h01, 0, 0, "sat_fill");
        cycle(8'h02, 0, 0, "sat_fill");
        cycle(8'h04, 0, 0, "sat_fill");
        cycle(8'h08, 0, 0, "sat_fill");
        for (int i = 0; i < 260; i++)
            cycle(i % 2 == 0 ? 8'h10 : 8'h20, 0, 0, "sat_loop");
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        chk("sat_ovf", 32'(overflow), 32'd1);
        cycle(8'h40, 0, 1, "clr_prio");
        chk("clr_prio_ovf", 32'(overflow), 32'd0);
        chk("clr_prio_drop", 32'(drop_cnt), 32'd0);
        chk("clr_prio_level", 32'(level), 32'd4);

        do_reset();
        cycle(8'h01, 0, 0, "mid_fill");
        cycle(8'h02, 0, 0, "mid_fill");
        cycle(8'h04, 0, 0, "mid_fill");
        chk("mid_level_pre", 32'(level), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("mid_level", 32'(level), 32'd0);
        chk("mid_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_code", 32'(bus.out_code), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        in_data = 8'd0;
        model_reset();
        cycle(8'h00, 1, 0, "post_rst_idle");

        begin
            logic [7:0] cur;
            cur = 8'd0;
            for (int i = 0; i < 600; i++) begin
                case ($urandom_range(0, 3))
                    0: cur = cur;
                    1: cur = 8'($urandom);
                    default: cur = 8'h01 << $urandom_range(0, 7);
                endcase
                cycle(cur, $urandom_range(0, 9) < 4, $urandom_range(0, 29) == 0, "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/onehot_event_logger.md
ONEHOT_EVENT_LOGGER -- requirements
Module: onehot_event_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_data, input, 8, decoder output vector from the upstream stage; nominally one-hot.
REQ-005 SHALL have port out_valid, output, 1, FIFO head entry present.
REQ-006 SHALL have port out_ready, input, 1, consumer accepts the head entry.
REQ-007 SHALL have port out_code, output, 3, encoded index of the head entry.
REQ-008 SHALL have port out_err, output, 1, head entry's vector was not exactly one-hot.
REQ-009 SHALL have port out_stamp, output, 8, timestamp of the head entry.
REQ-010 SHALL have port level, output, clog2(DEPTH)+1, current FIFO occupancy.
REQ-011 SHALL have port overflow, output, 1, sticky flag for a dropped event.
REQ-012 SHALL have port clr_ovf, input, 1, synchronous clear of overflow and drop_cnt.
REQ-013 SHALL have port drop_cnt, output, 8, count of dropped events.

Function
REQ-014 SHALL register in_data into prev_q every cycle; an event is in_data != prev_q at a rising edge.
REQ-015 SHALL build each event entry as follows:
- code: index of the lowest set bit of in_data, 0 if in_data is zero.
- err: 1 when popcount(in_data) != 1, which includes all-zero.
- stamp: free-running 8-bit cycle counter value at that edge.
REQ-016 SHALL run the cycle counter continuously, incrementing by 1 each cycle and wrapping 255 to 0.
REQ-017 SHALL write an event into the FIFO at the same edge it is detected, with out_valid high in the following cycle (1-cycle latency).
REQ-018 SHALL make the FIFO first-word-fall-through: out_valid = (level != 0), with out_code, out_err and out_stamp driven from the head.
REQ-019 SHALL pop the head when out_valid && out_ready; head outputs SHALL hold stable while out_valid && !out_ready.
REQ-020 SHALL accept a push while the FIFO is full only if a pop occurs in the same cycle; level is then unchanged.
REQ-021 SHALL drop an event that arrives while the FIFO is full with no pop, setting overflow and incrementing drop_cnt, saturating at 255.
REQ-022 SHALL give clr_ovf priority over a simultaneous drop: overflow=0 and drop_cnt=0 in that cycle.
REQ-023 SHALL leave out_code, out_err and out_stamp at 0 while empty.

Reset
REQ-024 SHALL on reset asynchronously clear: prev_q, the cycle counter, FIFO pointers, level, overflow, drop_cnt and out_valid.
REQ-025 SHALL discard all FIFO contents on reset asserted mid-operation.
REQ-026 SHALL treat a nonzero in_data at the first edge after reset release as an event, because prev_q resets to 0.

Configuration
REQ-027 SHALL support macro ONEHOT_LOGGER_TIMESTAMP_EN:
- Defined: the cycle counter and stamp storage are built and out_stamp behaves per REQ-015.
- Undefined: no counter or stamp storage is built and out_stamp is constant 0.

Structure
REQ-028 SHALL place the following in shared package onehot_logger_pkg:
- the entry struct typedef (code, err, stamp);
- constants CODE_W=3, STAMP_W=8, VEC_W=8;
- the encode/one-hot-check function.
REQ-029 SHALL implement storage in one sub-module logger_fifo (parameterised width/DEPTH, FWFT, level output).

Verification
REQ-030 SHALL cover: reset release with in_data=8'h04, out_ready=0 -> next cycle out_valid=1, out_code=2, out_err=0, out_stamp=0.
REQ-031 SHALL cover: in_data sequence 01,01,80 on consecutive edges -> exactly two entries, codes 0 then 7; the repeated 01 creates no entry.
REQ-032 SHALL cover: in_data=8'h0A then 8'h00 -> entries code=1/err=1 and code=0/err=1.
REQ-033 SHALL cover: DEPTH=4, out_ready=0, 6 distinct events -> level=4, overflow=1, drop_cnt=2; then clr_ovf for 1 cycle -> both 0.
REQ-034 SHALL cover: FIFO full with out_ready=1 and a new event in the same cycle -> level stays 4, no drop, entries remain in order.
REQ-035 SHALL cover: reset pulse with level=3 -> level=0 and out_valid=0 immediately; with the macro undefined, out_stamp is 0 for all entries.
